// File: rtl/nds_fifo_ptr.sv
// Mod-DEPTH wrap counter used for the FIFO read and write pointers.
// Wraps from DEPTH-1 back to 0 by compare, so DEPTH need not be a power of two.
module nds_fifo_ptr #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    // Pointer register: clear dominates increment; wrap explicitly at LAST.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/nds_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count,
// almost-full/almost-empty thresholds, synchronous flush and registered
// overflow/underflow pulses. Full/empty come from the count, never from
// pointer comparison, so any DEPTH in 2..256 works.
module nds_sync_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter int AFULL_LEVEL  = DEPTH - 1,
    parameter int AEMPTY_LEVEL = 1,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int ADDR_W = $clog2(DEPTH);

    // Elaboration-time parameter legality checks; they produce no hardware.
    if (DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
        $error("nds_sync_fifo: DEPTH must be in 2..256");
    end
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
        $error("nds_sync_fifo: AFULL_LEVEL must be in 1..DEPTH");
    end
    if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > DEPTH - 1) begin : g_bad_aempty
        $error("nds_sync_fifo: AEMPTY_LEVEL must be in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flush suppresses both accepts so nothing moves in a flush cycle.
    assign rd_acc = rd & ~empty & ~flush;
    assign wr_acc = wr & (~full | rd_acc) & ~flush;

    // Status flags decode only the registered count.
    assign empty        = (count == '0);
    assign full         = (count == CNT_W'(DEPTH));
    assign almost_empty = (count <= CNT_W'(AEMPTY_LEVEL));
    assign almost_full  = (count >= CNT_W'(AFULL_LEVEL));

    // First-word-fall-through: the head entry is always on rd_data.
    assign rd_data = mem[rd_ptr];

    nds_fifo_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .inc     (wr_acc),
        .ptr     (wr_ptr)
    );

    nds_fifo_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .inc     (rd_acc),
        .ptr     (rd_ptr)
    );

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Occupancy count: simultaneous accept leaves it unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Error pulses, one cycle after the rejected request; silent on flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ~flush & wr & ~wr_acc;
            underflow <= ~flush & rd & empty;
        end
    end

endmodule

// File: doc/nds_sync_fifo.md
Name: nds_sync_fifo

Overview:
- Parametrised single-clock FIFO; successor to the 1-entry ping-pong buffer.
- Generalised in width and depth, with first-word-fall-through read data.
- Adds occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and overflow/underflow error pulses.
- Used between APB/DMA datapath stages inside one clock domain, e.g. DMA channel burst staging.

Parameters:
- DATA_WIDTH, 32, width of each entry.
- DEPTH, 4, number of entries; legal range 2..256, any integer, power of two not required.
- AFULL_LEVEL, DEPTH-1, almost_full asserts when count >= AFULL_LEVEL; legal range 1..DEPTH.
- AEMPTY_LEVEL, 1, almost_empty asserts when count <= AEMPTY_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all entries and pointers.
- wr  input  1  push wr_data this cycle.
- wr_data  input  DATA_WIDTH  write data.
- rd  input  1  pop the head entry this cycle.
- rd_data  output  DATA_WIDTH  head entry; valid whenever empty=0.
- empty  output  1  no entries.
- full  output  1  DEPTH entries.
- almost_empty  output  1  count <= AEMPTY_LEVEL.
- almost_full  output  1  count >= AFULL_LEVEL.
- count  output  CNT_W  occupancy; CNT_W = $clog2(DEPTH+1).
- overflow  output  1  one-cycle pulse on a rejected write.
- underflow  output  1  one-cycle pulse on a rejected read.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - empty = 1, full = 0.
  - almost_empty = 1 (AEMPTY_LEVEL >= 0); almost_full = 0.
  - overflow = 0, underflow = 0.
  - Storage array is not reset; rd_data is don't-care while empty.
- Pointers:
  - ADDR_W = $clog2(DEPTH).
  - Each pointer wraps from DEPTH-1 to 0 explicitly, by compare, not by power-of-two rollover.
  - Full/empty are derived from count, not from pointer compare.
- Read data:
  - FWFT: rd_data = mem[rd_ptr], combinational from the array.
  - First write into an empty FIFO at edge N: empty=0 and rd_data valid in cycle N+1 (one-cycle write-to-read latency).
- Accepted write: wr_acc = wr & (~full | rd_acc). On an edge with wr_acc, mem[wr_ptr] <= wr_data and wr_ptr advances.
- Accepted read: rd_acc = rd & ~empty. On an edge with rd_acc, rd_ptr advances.
- Count update: count +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- Simultaneous events:
  - Full with wr & rd: both accepted, count stays DEPTH, no overflow.
  - Empty with wr & rd: read rejected (underflow pulses), write accepted, count becomes 1.
- Error pulses, registered, asserted the cycle after the offending edge for exactly one cycle:
  - overflow when wr & ~wr_acc.
  - underflow when rd & empty.
- Flush:
  - Dominates wr and rd in the same cycle.
  - Next cycle: pointers = 0, count = 0, empty = 1.
  - No overflow/underflow is generated in a flush cycle.
- Flags: all status outputs are registered or derived from the registered count; no combinational path from wr/rd to any flag.
- Reset mid-operation: contents are lost and all outputs return to reset values immediately (asynchronous).

Decomposition:
- No shared package needed; CNT_W and ADDR_W are local constants inside the module.
- One sub-module: nds_fifo_ptr, a parametrised mod-DEPTH wrap counter with inc and clr inputs, instantiated for wr_ptr and rd_ptr.
- Add parameter legality checks in a simulation-only initial block.

Test Plan:
- Reset then idle: with DEPTH=4, release reset_n -> empty=1, full=0, count=0, almost_empty=1, no error pulses.
- Fill and drain: write 0xA0..0xA3 on consecutive cycles, then read 4.
  - After the writes: full=1, count=4, almost_full=1.
  - rd_data sequence is 0xA0,0xA1,0xA2,0xA3.
  - Ends with empty=1.
- Wrap with DEPTH=3: perform 7 write/read pairs with data 1..7 -> read order 1..7, pointers wrap twice, count never exceeds 1.
- Boundary simultaneity:
  - At full (count=4), wr=1 rd=1 with data 0x55 -> count stays 4, no overflow, 0x55 read out last.
  - At empty, wr=1 rd=1 -> underflow pulse one cycle, count=1.
- Errors: write at full without rd -> overflow high exactly one cycle, contents unchanged; read at empty -> underflow one cycle.
- Flush and reset: with count=3, assert flush together with wr=1 -> next cycle count=0, empty=1, no overflow. Then refill 2 entries, drop reset_n mid-cycle -> outputs return to reset values before the next edge.
